// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Arbitrates between the instruction-side prefetcher and the data cache
//   for a single physical-memory (cacheline adaptor) port. One transaction is
//   in flight at a time. Requests are latched on grant, and the pmem_* outputs
//   are driven only from those latched copies. Each transaction is followed by
//   one DONE cycle before the arbiter returns to IDLE.
//
//   Optional feature: macro PMEM_ARB_STARVE_GUARD_EN. When it is defined, a
//   starvation counter lets a waiting instruction read win a tie after
//   STARVE_LIMIT consecutive data grants. When it is undefined, data always
//   wins ties and STARVE_LIMIT has no effect.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   inst_read/inst_address   instruction-side read request
//   inst_resp/inst_rdata     instruction completion pulse and line
//   data_read/data_write     data-side request (both high is a write)
//   data_address/data_wdata  data-side address and write-back line
//   data_resp/data_rdata     data completion pulse and line
//   pmem_read/pmem_write     request to the adaptor (registered)
//   pmem_address/pmem_wdata  latched request fields
//   pmem_resp/pmem_rdata     adaptor completion and read line
module pmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_read,
  input  logic [31:0]  inst_address,
  output logic         inst_resp,
  output logic [255:0] inst_rdata,
  input  logic         data_read,
  input  logic         data_write,
  input  logic [31:0]  data_address,
  input  logic [255:0] data_wdata,
  output logic         data_resp,
  output logic [255:0] data_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_t;

  state_t state;
  logic   data_req;
  logic   grant_inst;

  assign data_req = data_read | data_write;

`ifdef PMEM_ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // An instruction read wins when it is alone, or when data has already
  // taken LIMIT grants back to back while the read was waiting.
  assign grant_inst = inst_read & (~data_req | (starve_cnt == LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_inst)
        starve_cnt <= '0;
      else if (data_req && inst_read && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign grant_inst = inst_read & ~data_req;
`endif

  // The read/write kind is held in pmem_read/pmem_write themselves. Both are
  // registered, so they first appear in the cycle after the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst) begin
            state        <= INST;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            pmem_address <= inst_address;
            pmem_wdata   <= '0;
          end else if (data_req) begin
            state        <= DATA;
            pmem_read    <= ~data_write;  // read+write together counts as a write
            pmem_write   <= data_write;
            pmem_address <= data_address;
            pmem_wdata   <= data_wdata;
          end
        end
        INST, DATA: begin
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: state <= IDLE;  // DONE lasts exactly one cycle
      endcase
    end
  end

  // The completion is forwarded in the same cycle as pmem_resp. A response
  // that arrives outside INST/DATA (after a reset, for example) is ignored.
  assign inst_resp  = (state == INST) & pmem_resp;
  assign data_resp  = (state == DATA) & pmem_resp;
  assign inst_rdata = inst_resp ? pmem_rdata : '0;
  assign data_rdata = data_resp ? pmem_rdata : '0;

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits.
REQ-002 Port: clk  in  1  sole clock; all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: inst_read  in  1  instruction-side read request (from prefetch pf_read).
REQ-005 Port: inst_address  in  32  instruction-side line address.
REQ-006 Port: inst_resp  out  1  one-cycle completion pulse to instruction side.
REQ-007 Port: inst_rdata  out  256  line returned to instruction side.
REQ-008 Port: data_read  in  1  data-cache read request.
REQ-009 Port: data_write  in  1  data-cache write-back request.
REQ-010 Port: data_address  in  32  data-side line address.
REQ-011 Port: data_wdata  in  256  write-back line.
REQ-012 Port: data_resp  out  1  one-cycle completion pulse to data side.
REQ-013 Port: data_rdata  out  256  line returned to data side.
REQ-014 Port: pmem_read / pmem_write  out  1 each  request to cacheline adaptor.
REQ-015 Port: pmem_address  out  32; pmem_wdata  out  256  latched request fields.
REQ-016 Port: pmem_resp  in  1; pmem_rdata  in  256  adaptor completion and read line.

Function
REQ-017 FSM states SHALL be IDLE, INST, DATA, DONE.
REQ-018 IDLE: data request (data_read|data_write) only -> DATA; inst_read only -> INST; none -> stay.
REQ-019 IDLE, both requesting: DATA, unless starve counter == STARVE_LIMIT, then INST.
REQ-020 On grant the arbiter SHALL latch address, wdata, read/write kind; pmem_* outputs driven only from latched values, from the cycle after grant.
REQ-021 INST/DATA: pmem_read (or pmem_write) SHALL stay asserted until pmem_resp; on pmem_resp the granted side's resp pulses that same cycle with rdata = pmem_rdata; ungranted side's resp stays 0.
REQ-022 After pmem_resp, FSM SHALL enter DONE for exactly one cycle (pmem_read/write low), then IDLE; minimum turnaround request-to-next-grant is 1 cycle after DONE.
REQ-023 data_read and data_write both high SHALL be treated as write.
REQ-024 Requesters hold request until resp; a request dropped mid-transaction SHALL NOT abort it; resp still pulses.
REQ-025 Starve counter (width clog2(STARVE_LIMIT+1)): +1 on each DATA grant while inst_read high; cleared on INST grant; saturates at STARVE_LIMIT.
REQ-026 rdata outputs SHALL be 0 when corresponding resp is 0.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, clear latches and starve counter, drive all outputs 0.
REQ-028 Reset mid-transaction SHALL drop it with no resp pulse; first grant after release follows REQ-018/019.

Configuration
REQ-029 Macro PMEM_ARB_STARVE_GUARD_EN: defined -> starve counter and REQ-019 override active; undefined -> counter absent, data always wins ties, STARVE_LIMIT ignored.

Verification
REQ-030 inst_read=1, addr 0x0000_0100, no data -> pmem_read=1 addr 0x100 next cycle; pmem_resp with line 0xAB..AB -> inst_resp=1, inst_rdata=0xAB..AB same cycle.
REQ-031 data_write=1 addr 0x0000_2000, wdata 0x5A..5A -> pmem_write=1 with those values until pmem_resp; data_resp pulses once; pmem_read stays 0.
REQ-032 Both request continuously, guard enabled, STARVE_LIMIT=4 -> grants DATA x4 then INST, repeating; guard disabled -> INST never granted.
REQ-033 Change data_address to 0xFFFF_FFE0 during DATA -> pmem_address keeps granted value until DONE.
REQ-034 rst low while in INST with pmem_read=1 -> outputs 0 immediately, no inst_resp; after release and pmem_resp ignored, IDLE.
REQ-035 Back-to-back inst_read -> exactly one DONE cycle with pmem_read=0 between transactions.
